// File: rtl/serial_pkg.sv
// Shared encodings for the serializer and the downstream Mealy sequence detectors.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // 1010 detector states, named by the longest matched prefix.
  typedef enum logic [1:0] {
    DET_S0    = 2'd0,
    DET_S1    = 2'd1,
    DET_S10   = 2'd2,
    DET_S101  = 2'd3
  } det_state_e;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word handshake and serial bit stream between a word source and the serializer.
interface bit_serializer_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             x_out;
  logic             bit_valid;
  logic             frame_done;

  modport master (
    output data_in, load,
    input  ready, x_out, bit_valid, frame_done
  );

  modport slave (
    input  data_in, load,
    output ready, x_out, bit_valid, frame_done
  );
endinterface

// File: rtl/bit_serializer_piso_shift_reg.sv
// Parallel-load shift register; nxt_bit is the bit that will sit at the output end after this edge.
module piso_shift_reg
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             nxt_bit
);

  logic [WIDTH-1:0] sr_p0;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_p0;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = MSB_FIRST ? {sr_p0[WIDTH-2:0], 1'b0} : {1'b0, sr_p0[WIDTH-1:1]};
    end
  end

  assign nxt_bit = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_p0 <= '0;
    end else begin
      sr_p0 <= sr_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out front end for the sequence detectors; gap-free across back-to-back words.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  ser_state_e      state_p0, state_d;
  logic [CW-1:0]   cnt_p0, cnt_d;
  logic            accept, shift, nxt_bit;
  logic            x_p0, vld_p0, fd_p0, rdy_p0;

  // Counter holds bits remaining after the one on x_out; zero marks the last bit,
  // which is also the only SHIFT cycle where a new word may be taken.
  always_comb begin
    state_d = state_p0;
    cnt_d   = cnt_p0;
    accept  = 1'b0;
    shift   = 1'b0;
    case (state_p0)
      IDLE: begin
        if (bus.load) begin
          accept  = 1'b1;
          state_d = SHIFT;
          cnt_d   = LAST_IDX;
        end
      end
      SHIFT: begin
        if (cnt_p0 == '0) begin
          if (bus.load) begin
            accept = 1'b1;
            cnt_d  = LAST_IDX;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift = 1'b1;
          cnt_d = cnt_p0 - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .shift   (shift),
    .din     (bus.data_in),
    .nxt_bit (nxt_bit)
  );

  // Output stage: every output is a flop fed from next-state values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      x_p0     <= IDLE_LEVEL;
      vld_p0   <= 1'b0;
      fd_p0    <= 1'b0;
      rdy_p0   <= 1'b1;
    end else begin
      state_p0 <= state_d;
      cnt_p0   <= cnt_d;
      x_p0     <= (state_d == SHIFT) ? nxt_bit : IDLE_LEVEL;
      vld_p0   <= (state_d == SHIFT);
      fd_p0    <= (state_d == SHIFT) && (cnt_d == '0);
      rdy_p0   <= (state_d == IDLE) || (cnt_d == '0);
    end
  end

  assign bus.x_out      = x_p0;
  assign bus.bit_valid  = vld_p0;
  assign bus.frame_done = fd_p0;
  assign bus.ready      = rdy_p0;

endmodule
